// File: rtl/dcpu_pkg.sv
// Shared definitions for the dcpu memory bus: FSM encoding, abort value and address-region decode.
package dcpu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RAM  = 2'd1;
  localparam logic [1:0] ST_IO   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [15:0] ABORT_DAT = 16'hDEAD;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_IO   = 2'd1,
    REG_NONE = 2'd2
  } region_t;

  // The IO window is 256-aligned, so a match on the upper byte is sufficient.
  function automatic region_t decode_region(input logic [15:0] addr, input int ram_aw,
                                            input logic [15:0] io_base);
    if ((addr >> ram_aw) == 16'd0) return REG_RAM;
    if (addr[15:8] == io_base[15:8]) return REG_IO;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/dcpu_bus_ram.sv
// Synchronous single-port RAM, one-cycle read latency, written as an inferable block RAM.
module dcpu_bus_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdat,
  output logic [15:0]   rdat
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdat;
      rdat <= mem[addr];
    end
  end

endmodule

// File: rtl/dcpu_bus.sv
// Single-master dcpu bus: decodes to block RAM, a handshaked IO port, or unmapped space.
// Optional IO timeout/abort is enabled by defining DCPU_BUS_TIMEOUT_EN.
module dcpu_bus
  import dcpu_pkg::*;
#(
  parameter int          RAM_AW  = 12,
  parameter logic [15:0] IO_BASE = 16'hFF00,
  parameter int          TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  input  logic        i_we,
  input  logic        i_cs,
  output logic        o_ack,
  output logic [7:0]  o_io_addr,
  output logic [15:0] o_io_dat,
  input  logic [15:0] i_io_dat,
  output logic        o_io_we,
  output logic        o_io_stb,
  input  logic        i_io_ack,
  output logic        o_err
);

  logic [1:0]  state;
  region_t     region;
  logic        start;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_rdat;
  logic        wr_q;
  logic [15:0] data_q;
  logic        tmo_hit;

  assign start  = (state == ST_IDLE) && i_cs;
  assign region = decode_region(i_addr, RAM_AW, IO_BASE);
  assign ram_en = start && (region == REG_RAM);
  assign ram_we = ram_en && i_we;

  dcpu_bus_ram #(.AW(RAM_AW)) u_ram (
    .clk  (i_clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (i_addr[RAM_AW-1:0]),
    .wdat (i_dat),
    .rdat (ram_rdat)
  );

`ifdef DCPU_BUS_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        err_q;

  // An ack in the same cycle as expiry takes priority over the abort.
  assign tmo_hit = (state == ST_IO) && !i_io_ack && (tmo_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state == ST_IO) ? tmo_cnt + 16'd1 : 16'd0;
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign o_err   = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_IDLE;
      wr_q      <= 1'b0;
      data_q    <= '0;
      o_io_addr <= '0;
      o_io_dat  <= '0;
      o_io_we   <= 1'b0;
      o_io_stb  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_cs) begin
            case (region)
              REG_RAM: begin
                wr_q  <= i_we;
                state <= ST_RAM;
              end
              REG_IO: begin
                o_io_addr <= 8'(i_addr - IO_BASE);
                o_io_dat  <= i_dat;
                o_io_we   <= i_we;
                o_io_stb  <= 1'b1;
                state     <= ST_IO;
              end
              default: begin
                data_q <= '0;
                state  <= ST_DONE;
              end
            endcase
          end
        end
        ST_RAM: state <= ST_IDLE;
        ST_IO: begin
          if (i_io_ack) begin
            data_q   <= o_io_we ? 16'd0 : i_io_dat;
            o_io_stb <= 1'b0;
            state    <= ST_DONE;
          end else if (tmo_hit) begin
            data_q   <= ABORT_DAT;
            o_io_stb <= 1'b0;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Ack and read data are decoded purely from registered state.
  assign o_ack = (state == ST_RAM) || (state == ST_DONE);
  assign o_dat = (state == ST_RAM)  ? (wr_q ? 16'd0 : ram_rdat) :
                 (state == ST_DONE) ? data_q : 16'd0;

endmodule

// File: tb/tb_dcpu_bus.sv
// Self-checking bench for dcpu_bus: vector table plus hand-written multi-cycle sequences,
// read data checked through an expected-data queue popped on every o_ack.
module tb_dcpu_bus;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [15:0] wdat;
  logic [15:0] rdat;
  logic        we;
  logic        cs;
  logic        ack;
  logic [7:0]  io_addr;
  logic [15:0] io_wdat;
  logic [15:0] io_rdat;
  logic        io_we;
  logic        io_stb;
  logic        io_ack;
  logic        err;

  always #5 clk = ~clk;

  dcpu_bus #(.RAM_AW(12), .IO_BASE(16'hFF00), .TIMEOUT(15)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_addr    (addr),
    .i_dat     (wdat),
    .o_dat     (rdat),
    .i_we      (we),
    .i_cs      (cs),
    .o_ack     (ack),
    .o_io_addr (io_addr),
    .o_io_dat  (io_wdat),
    .i_io_dat  (io_rdat),
    .o_io_we   (io_we),
    .o_io_stb  (io_stb),
    .i_io_ack  (io_ack),
    .o_err     (err)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdat;
    logic        we;
    logic        is_io;
    int          io_wait;
    logic [15:0] io_rdat;
    logic [7:0]  exp_io_addr;
    logic [15:0] exp_dat;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ram_writes = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] d, input logic w,
                              input logic io, input int wait_c, input logic [15:0] io_d,
                              input logic [7:0] eio, input logic [15:0] ed);
    vec_t v;
    v.addr = a; v.wdat = d; v.we = w; v.is_io = io; v.io_wait = wait_c;
    v.io_rdat = io_d; v.exp_io_addr = eio; v.exp_dat = ed;
    return v;
  endfunction

  // Scoreboard: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ack) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_ack: got ack with data %h, expected no ack at %0t", rdat, $time);
      end else begin
        check("ack_data", rdat, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (dut.ram_we) ram_writes++;
  end

  task automatic drive_req(input logic [15:0] a, input logic [15:0] d, input logic w);
    @(posedge clk); #1;
    cs = 1'b1; addr = a; wdat = d; we = w;
  endtask

  task automatic apply_stimulus(input vec_t v);
    drive_req(v.addr, v.wdat, v.we);
    exp_q.push_back(v.exp_dat);
    @(posedge clk); #1;
    cs = 1'b0;
    @(negedge clk);
    if (!v.is_io) begin
      check("ack_latency", 16'(ack), 16'd1);
      check("no_io_stb", 16'(io_stb), 16'd0);
    end else begin
      check("io_addr", 16'(io_addr), 16'(v.exp_io_addr));
      check("io_we", 16'(io_we), 16'(v.we));
      if (v.we) check("io_wdat", io_wdat, v.wdat);
      for (int k = 1; k <= v.io_wait; k++) begin
        check("io_stb_held", 16'(io_stb), 16'd1);
        check("no_early_ack", 16'(ack), 16'd0);
        if (k == v.io_wait) begin
          io_ack  = 1'b1;
          io_rdat = v.io_rdat;
        end
        @(negedge clk);
      end
      io_ack = 1'b0;
      check("io_stb_drop", 16'(io_stb), 16'd0);
      check("io_ack_latency", 16'(ack), 16'd1);
    end
    @(negedge clk);
    check("ack_single", 16'(ack), 16'd0);
  endtask

  initial begin
    int exp_writes;
    int w0;

    rst_n = 1'b1; cs = 1'b0; addr = '0; wdat = '0; we = 1'b0; io_rdat = '0; io_ack = 1'b0;
    #2 rst_n = 1'b0;
    #20;
    check("rst_ack", 16'(ack), 16'd0);
    check("rst_dat", rdat, 16'd0);
    check("rst_io_stb", 16'(io_stb), 16'd0);
    check("rst_io_addr", 16'(io_addr), 16'd0);
    check("rst_io_we", 16'(io_we), 16'd0);
    check("rst_io_dat", io_wdat, 16'd0);
    check("rst_err", 16'(err), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //            addr      wdat      we    io    wait io_rdat   io_addr exp_dat
    vecs.push_back(mk(16'h0010, 16'h1234, 1'b1, 1'b0, 0, 16'h0000, 8'h00, 16'h0000));
    vecs.push_back(mk(16'h0010, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 8'h00, 16'h1234));
    vecs.push_back(mk(16'h0000, 16'h1111, 1'b1, 1'b0, 0, 16'h0000, 8'h00, 16'h0000));
    vecs.push_back(mk(16'h0001, 16'h2222, 1'b1, 1'b0, 0, 16'h0000, 8'h00, 16'h0000));
    vecs.push_back(mk(16'h0FFF, 16'hABCD, 1'b1, 1'b0, 0, 16'h0000, 8'h00, 16'h0000));
    vecs.push_back(mk(16'h0FFF, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 8'h00, 16'hABCD));
    vecs.push_back(mk(16'h1000, 16'h5555, 1'b1, 1'b0, 0, 16'h0000, 8'h00, 16'h0000));
    vecs.push_back(mk(16'h1000, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 8'h00, 16'h0000));
    vecs.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 8'h00, 16'h1111));
    vecs.push_back(mk(16'hFF05, 16'h0000, 1'b0, 1'b1, 3, 16'hBEEF, 8'h05, 16'hBEEF));
    vecs.push_back(mk(16'hFF10, 16'hCAFE, 1'b1, 1'b1, 1, 16'hFFFF, 8'h10, 16'h0000));
    vecs.push_back(mk(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1, 16'h7777, 8'hFF, 16'h7777));
    vecs.push_back(mk(16'hFEFF, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 8'h00, 16'h0000));
    vecs.push_back(mk(16'h8000, 16'h9999, 1'b1, 1'b0, 0, 16'h0000, 8'h00, 16'h0000));
    vecs.push_back(mk(16'h8000, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 8'h00, 16'h0000));

    exp_writes = 0;
    foreach (vecs[i]) if (vecs[i].we && !vecs[i].is_io && vecs[i].addr < 16'h1000) exp_writes++;
    w0 = ram_writes;
    foreach (vecs[i]) apply_stimulus(vecs[i]);
    check("ram_write_count", 16'(ram_writes - w0), 16'(exp_writes));

    // Back-to-back reads with cs held high: the second is taken after one idle cycle.
    w0 = ram_writes;
    drive_req(16'h0000, 16'h0000, 1'b0);
    exp_q.push_back(16'h1111);
    @(posedge clk); #1;
    addr = 16'h0001;
    exp_q.push_back(16'h2222);
    @(negedge clk);
    check("b2b_ack1", 16'(ack), 16'd1);
    @(negedge clk);
    check("b2b_gap", 16'(ack), 16'd0);
    @(posedge clk); #1;
    cs = 1'b0;
    @(negedge clk);
    check("b2b_ack2", 16'(ack), 16'd1);
    @(negedge clk);
    check("b2b_ack2_single", 16'(ack), 16'd0);
    check("b2b_no_write", 16'(ram_writes - w0), 16'd0);

    // A stray peripheral ack while idle must be ignored.
    @(posedge clk); #1;
    io_ack = 1'b1;
    @(negedge clk);
    check("stray_io_ack_no_ack", 16'(ack), 16'd0);
    @(posedge clk); #1;
    io_ack = 1'b0;
    @(negedge clk);
    check("stray_io_ack_no_ack2", 16'(ack), 16'd0);

`ifdef DCPU_BUS_TIMEOUT_EN
    drive_req(16'hFF00, 16'h0000, 1'b0);
    exp_q.push_back(16'hDEAD);
    @(posedge clk); #1;
    cs = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 15; k++) begin
      check("tmo_stb_held", 16'(io_stb), 16'd1);
      check("tmo_no_early_ack", 16'(ack), 16'd0);
      @(negedge clk);
    end
    check("tmo_stb_drop", 16'(io_stb), 16'd0);
    check("tmo_ack", 16'(ack), 16'd1);
    check("tmo_err_set", 16'(err), 16'd1);
    @(negedge clk);
    check("tmo_ack_single", 16'(ack), 16'd0);
    apply_stimulus(mk(16'h0FFF, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 8'h00, 16'hABCD));
    check("tmo_err_sticky", 16'(err), 16'd1);
`else
    check("err_tied_low", 16'(err), 16'd0);
`endif

    // Reset in the middle of an IO write: everything drops asynchronously, no ack follows.
    drive_req(16'hFF20, 16'h5A5A, 1'b1);
    @(posedge clk); #1;
    cs = 1'b0;
    @(negedge clk);
    check("mid_io_stb", 16'(io_stb), 16'd1);
    check("mid_io_addr", 16'(io_addr), 16'h0020);
    check("mid_io_dat", io_wdat, 16'h5A5A);
    #2 rst_n = 1'b0;
    #1;
    check("arst_io_stb", 16'(io_stb), 16'd0);
    check("arst_ack", 16'(ack), 16'd0);
    check("arst_dat", rdat, 16'd0);
    check("arst_io_addr", 16'(io_addr), 16'd0);
    check("arst_io_dat", io_wdat, 16'd0);
    check("arst_io_we", 16'(io_we), 16'd0);
    check("arst_err", 16'(err), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_no_ack", 16'(ack), 16'd0);
    check("post_rst_no_stb", 16'(io_stb), 16'd0);
    apply_stimulus(mk(16'h0010, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 8'h00, 16'h1234));

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL pending_acks: got %0d outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcpu_bus.md
# dcpu_bus

Single-master memory bus for the dcpu core. Sits directly downstream of the CPU's memory port: it consumes `o_addr/o_dat/o_we/o_cs` and returns `i_dat/i_ack`. It decodes each request to an internal block RAM, a handshaked peripheral (IO) port, or an unmapped region, and returns exactly one single-cycle acknowledge per transaction.

## Interface
- `RAM_AW`, 12: RAM address width; RAM covers words `0x0000 .. 2^RAM_AW-1`.
- `IO_BASE`, 16'hFF00: base of the 256-word IO window `IO_BASE .. IO_BASE+0xFF`. Must be 256-aligned and above the RAM.
- `TIMEOUT`, 15: IO wait cycles before abort. Used only with the timeout feature.

Ports:
- `i_clk`  in  1  clock, single domain.
- `i_reset_n`  in  1  reset; asynchronous, active-low.
- `i_addr`  in  16  CPU word address.
- `i_dat`  in  16  CPU write data.
- `o_dat`  out  16  read data to CPU; valid while `o_ack`=1.
- `i_we`  in  1  write strobe, qualified by `i_cs`.
- `i_cs`  in  1  request valid.
- `o_ack`  out  1  one-cycle transaction complete.
- `o_io_addr`  out  8  IO register offset, `i_addr - IO_BASE`.
- `o_io_dat`  out  16  IO write data.
- `i_io_dat`  in  16  IO read data; sampled when `i_io_ack`=1.
- `o_io_we`  out  1  IO write.
- `o_io_stb`  out  1  IO request; held until `i_io_ack`.
- `i_io_ack`  in  1  IO completion.
- `o_err`  out  1  sticky IO-timeout flag.

## Operation
- States: `IDLE`, `RAM`, `IO`, `DONE`.
- In `IDLE` with `i_cs`=1, the address is decoded at the clock edge:
  - **RAM hit:** the read address is registered. If `i_we`=1, the RAM word is written at this edge (exactly once). Go to `RAM`.
  - **IO hit:** register `o_io_addr`, `o_io_dat` and `o_io_we`. Set `o_io_stb`=1. Go to `IO`.
  - **Unmapped:** write is dropped; read data is 0. Go to `DONE`.
- **`RAM` state:** `o_ack`=1 and `o_dat` = RAM read word (0 for writes). Return to `IDLE`.
- **`IO` state:** hold `o_io_stb` and its outputs stable. When `i_io_ack`=1: capture `i_io_dat` (0 for writes), clear `o_io_stb`, go to `DONE`.
- **`DONE` state:** `o_ack`=1 with the captured data. Return to `IDLE`.
- Once started, a transaction completes regardless of `i_cs` or `i_addr` changes.
- New requests are accepted only in `IDLE`. The CPU keeps `i_cs` high across back-to-back fetch/execute accesses; every `IDLE` cycle with `i_cs`=1 starts a new transaction.
- `o_err` is set only by a timeout. Only reset clears it.

## Timing
- Reset (async assert, sync release): state `IDLE`. `o_ack`, `o_dat`, `o_io_addr`, `o_io_dat`, `o_io_we`, `o_io_stb` and `o_err` are all 0. RAM contents are not reset.
- Reset mid-transaction drops `o_io_stb` immediately. No ack is issued.
- All outputs are registered; there is no combinational path from `i_*` to `o_*`.
- **RAM or unmapped access:** `o_ack` is high in cycle N+1 when `i_cs` is sampled at edge N. The minimum spacing is 2 cycles per transaction.
- **IO access:** `o_io_stb` rises at N+1. When `i_io_ack` is sampled at edge M, `o_io_stb` falls and `o_ack` is high at M+1.
- If `i_io_ack` is high in the same cycle `o_io_stb` first rises, the access completes after the minimum wait.
- `i_io_ack` outside the `IO` state is ignored.
- Address arithmetic is 16-bit unsigned. There is no wrap: `IO_BASE+0xFF` is the last IO word.

## Configuration
- `DCPU_BUS_TIMEOUT_EN` defined:
  - A counter runs in `IO`, clearing on entry.
  - If `TIMEOUT` cycles elapse without `i_io_ack`: drop `o_io_stb`, load read data `16'hDEAD` (writes are lost), set `o_err`, go to `DONE`.
  - `i_io_ack` arriving in the same cycle as the timeout wins.
- Undefined:
  - There is no counter; `IO` waits indefinitely.
  - `o_err` is tied to 0.

## Structure
- The shared `dcpu_pkg` holds the state encoding, the `16'hDEAD` abort value, and the region-decode constants and helpers.
- Sub-module `dcpu_bus_ram`: a synchronous single-port RAM (`2^RAM_AW` x 16) with one-cycle read latency and write-enable. It is inferable as block RAM.

## Test plan
- **RAM write/read:** write 0x1234 to 0x0010, then read 0x0010 → ack 1 cycle after each request; read returns 0x1234; exactly one RAM write.
- **Back-to-back:** read 0x0000 immediately followed by a read of 0x0001 with `i_cs` held high → two separate acks, correct data for each, one idle cycle between them.
- **IO read:** read 0xFF05, peripheral acks 3 cycles after strobe with 0xBEEF → `o_io_addr`=0x05, `o_io_stb` high for 3 cycles, `o_ack` with 0xBEEF one cycle after `i_io_ack`.
- **Unmapped:** write then read 0x8000 → ack after 1 cycle, read data 0, no IO strobe.
- **Timeout (`_EN`):** IO read 0xFF00 with no peripheral ack → strobe drops after 15 cycles, ack with 0xDEAD, `o_err`=1 until reset.
- **Reset mid-IO:** assert `i_reset_n`=0 while `o_io_stb`=1 → all outputs 0 asynchronously, no ack; after release, a RAM read works normally.
